// File: rtl/sound_pkg.sv
// Shared types and constants for the sound sequencer: FSM states, note table, counter widths.
package sound_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam int NUM_NOTES = 4;
  localparam int HP_W      = 16;
  localparam int DUR_W     = 22;

  // Half-periods in clk25 cycles: C5, E5, G5, C6
  localparam logic [HP_W-1:0] NOTE_HP [NUM_NOTES] = '{16'd23901, 16'd18968, 16'd15944, 16'd11939};

  function automatic logic [HP_W-1:0] note_hp(input logic [1:0] idx, input int unsigned shift);
    return NOTE_HP[idx] >> shift;
  endfunction

endpackage

// File: rtl/sound_sequencer_if.sv
// Play request in, speaker and busy out; the game core drives the master side.
interface sound_sequencer_if;
  logic PlayAgain;
  logic Speaker;
  logic Busy;

  modport master (output PlayAgain, input Speaker, input Busy);
  modport slave  (input PlayAgain, output Speaker, output Busy);
endinterface

// File: rtl/tone_divider.sv
// Square-wave generator: each phase lasts half_period cycles (zero clamps to one).
module tone_divider
  import sound_pkg::*;
(
  input  logic            clk25,
  input  logic            Reset,
  input  logic            en,
  input  logic            clr,
  input  logic [HP_W-1:0] half_period,
  output logic            sq
);

  logic [HP_W-1:0] count;
  logic [HP_W-1:0] hp_eff;

  assign hp_eff = (half_period == '0) ? HP_W'(1) : half_period;

  always_ff @(posedge clk25 or posedge Reset) begin
    if (Reset) begin
      sq    <= 1'b0;
      count <= '0;
    end else if (clr) begin
      sq    <= 1'b1;
      count <= '0;
    end else if (en) begin
      if (count == hp_eff - HP_W'(1)) begin
        sq    <= ~sq;
        count <= '0;
      end else begin
        count <= count + HP_W'(1);
      end
    end else begin
      sq    <= 1'b0;
      count <= '0;
    end
  end

endmodule

// File: rtl/sound_sequencer.sv
// Plays a four-note arpeggio with a silent gap after each note on every rising edge of PlayAgain.
// state | meaning
// IDLE  | silent, waiting for a PlayAgain rising edge
// PLAY  | note note_idx sounding for NOTE_CYCLES cycles
// GAP   | silence for GAP_CYCLES cycles after the current note
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned NOTE_CYCLES = 2500000,
  parameter int unsigned GAP_CYCLES  = 250000,
  parameter int unsigned HP_SHIFT    = 0
) (
  input logic               clk25,
  input logic               Reset,
  sound_sequencer_if.slave  bus
);

  state_t           state, state_nxt;
  logic [1:0]       note_idx, note_nxt;
  logic [DUR_W-1:0] dur_cnt, dur_nxt;
  logic             trig_d;
  logic             start;
  logic             note_done, gap_done;
  logic             div_en, div_clr;
  logic             speaker;
  logic [HP_W-1:0]  half_period;

  assign start       = bus.PlayAgain & ~trig_d;
  assign note_done   = (dur_cnt == DUR_W'(NOTE_CYCLES - 1));
  assign gap_done    = (dur_cnt == DUR_W'(GAP_CYCLES - 1));
  assign half_period = note_hp(note_idx, HP_SHIFT);

  always_ff @(posedge clk25 or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      note_idx <= '0;
      dur_cnt  <= '0;
      trig_d   <= 1'b0;
    end else begin
      state    <= state_nxt;
      note_idx <= note_nxt;
      dur_cnt  <= dur_nxt;
      trig_d   <= bus.PlayAgain;
    end
  end

  // A fresh edge overrides every terminal count, so a retrigger always restarts at note 0.
  always_comb begin
    state_nxt = state;
    note_nxt  = note_idx;
    dur_nxt   = dur_cnt;
    div_en    = 1'b0;
    div_clr   = 1'b0;
    if (start) begin
      state_nxt = PLAY;
      note_nxt  = '0;
      dur_nxt   = '0;
      div_clr   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          dur_nxt  = '0;
          note_nxt = '0;
        end
        PLAY: begin
          if (note_done) begin
            state_nxt = GAP;
            dur_nxt   = '0;
          end else begin
            div_en  = 1'b1;
            dur_nxt = dur_cnt + DUR_W'(1);
          end
        end
        GAP: begin
          if (gap_done) begin
            dur_nxt = '0;
            if (note_idx == 2'(NUM_NOTES - 1)) begin
              state_nxt = IDLE;
              note_nxt  = '0;
            end else begin
              state_nxt = PLAY;
              note_nxt  = note_idx + 2'd1;
              div_clr   = 1'b1;
            end
          end else begin
            dur_nxt = dur_cnt + DUR_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          note_nxt  = '0;
          dur_nxt   = '0;
        end
      endcase
    end
  end

  tone_divider u_tone (
    .clk25       (clk25),
    .Reset       (Reset),
    .en          (div_en),
    .clr         (div_clr),
    .half_period (half_period),
    .sq          (speaker)
  );

  assign bus.Speaker = speaker;
  assign bus.Busy    = (state != IDLE);

endmodule
